// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, the nop encoding and the prefetch entry
// layout passed from fetch to decode.
package cpu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_RESET = 2'd0,
    FS_RUN   = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with synchronous clear and async active-low reset.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rdPtr_q, wrPtr_q;
  logic [CW-1:0]  count_q;
  logic           doPush, doPop;

  assign doPop   = pop_i & (count_q != '0);
  assign doPush  = push_i & ((count_q != CW'(DEPTH)) | doPop);
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited bus requests, prefetch FIFO
// and decode register. FETCH_ALIGN_CHECK_EN turns misaligned targets into adel entries.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic        jumpD,
  input  logic [31:0] pcbranchD,
  input  logic [31:0] pcjumpD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        adelD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  // Outstanding count can reach dropped-plus-live, i.e. twice the FIFO depth.
  localparam int CW  = $clog2(FIFO_DEPTH) + 2;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t   state_q;
  logic [31:0]    fpc_q, instrD_q, pcD_q;
  logic [CW-1:0]  outst_q, outst_d, drop_q, drop_d, live;
  logic           validD_q, adelD_q;
  logic [FCW-1:0] fifoCnt;
  logic           fifoEmpty;
  fetch_entry_t   fifoHead, newEntry;
  logic           redirect, accept, credit, misaligned, errPush, respLive;
  logic           haveNew, advance, bypass, push, pop;
  logic [31:0]    tgtRaw, target;

  assign redirect = (pcsrcD | jumpD) & validD_q & ~stallD;
  assign tgtRaw   = jumpD ? pcjumpD : pcbranchD;
  assign live     = outst_q - drop_q;
  assign credit   = ({{(CW-FCW){1'b0}}, fifoCnt} + live) < CW'(FIFO_DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
  assign target     = tgtRaw;
  assign misaligned = (fpc_q[1:0] != 2'b00);
  // Wait for live responses to drain so the error entry stays in program order.
  assign errPush    = (state_q == FS_RUN) & misaligned & ~redirect & (live == '0) &
                      (fifoCnt < FCW'(FIFO_DEPTH));
`else
  assign target     = tgtRaw & ~32'h3;
  assign misaligned = 1'b0;
  assign errPush    = 1'b0;
`endif

  assign inst_req  = (state_q == FS_RUN) & credit & ~redirect & ~misaligned;
  assign inst_addr = fpc_q;
  assign accept    = inst_req & inst_addr_ok;
  assign respLive  = inst_data_ok & (drop_q == '0) & ~redirect;
  assign haveNew   = respLive | errPush;

  always_comb begin
    newEntry = '{pc: fpc_q - 32'({outst_q, 2'b00}), instr: inst_rdata, adel: 1'b0};
    if (errPush) newEntry = '{pc: fpc_q, instr: NOP_INSTR, adel: 1'b1};
  end

  assign advance = (~stallD | ~validD_q) & ~redirect;
  assign bypass  = advance & fifoEmpty & haveNew;
  assign push    = haveNew & ~bypass;
  assign pop     = advance & ~fifoEmpty;

  always_comb begin
    outst_d = outst_q + CW'(accept) - CW'(inst_data_ok);
    drop_d  = drop_q;
    if (redirect)                          drop_d = outst_d;
    else if (inst_data_ok && drop_q != '0) drop_d = drop_q - 1'b1;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(FCW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect),
    .data_i  (newEntry),
    .data_o  (fifoHead),
    .count_o (fifoCnt),
    .empty_o (fifoEmpty)
  );

  // Decode register takes the FIFO head first, else bypasses a fresh word, else a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FS_RESET;
      fpc_q    <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      instrD_q <= NOP_INSTR;
      pcD_q    <= '0;
      validD_q <= 1'b0;
      adelD_q  <= 1'b0;
    end else begin
      case (state_q)
        FS_RESET: state_q <= FS_RUN;
        FS_RUN:   if (errPush) state_q <= FS_HALT;
        FS_HALT:  if (redirect) state_q <= FS_RUN;
        default:  state_q <= FS_RESET;
      endcase
      if (redirect)    fpc_q <= target;
      else if (accept) fpc_q <= fpc_q + 32'd4;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      if (redirect) begin
        validD_q <= 1'b0;
        instrD_q <= NOP_INSTR;
        adelD_q  <= 1'b0;
      end else if (advance) begin
        if (!fifoEmpty) begin
          validD_q <= 1'b1;
          pcD_q    <= fifoHead.pc;
          instrD_q <= fifoHead.instr;
          adelD_q  <= fifoHead.adel;
        end else if (haveNew) begin
          validD_q <= 1'b1;
          pcD_q    <= newEntry.pc;
          instrD_q <= newEntry.instr;
          adelD_q  <= newEntry.adel;
        end else begin
          validD_q <= 1'b0;
          instrD_q <= NOP_INSTR;
          adelD_q  <= 1'b0;
        end
      end
    end
  end

  assign instrD = instrD_q;
  assign pcD    = pcD_q;
  assign validD = validD_q;
  assign adelD  = adelD_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bus responder that returns each address as its
// data, an instruction-stream model of program order, and directed redirect/stall/reset cases.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallD = 1'b0, pcsrcD = 1'b0, jumpD = 1'b0;
  logic [31:0] pcbranchD = '0, pcjumpD = '0;
  logic [31:0] instrD, pcD, inst_addr;
  logic        validD, adelD, inst_req;
  logic        inst_addr_ok = 1'b1;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busLat = 1;
  int acceptCount = 0;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } busTxn_t;
  busTxn_t busQ[$];

  logic [31:0] expPc = RST_PC, expReq = RST_PC, heldPc = '0, heldInstr = '0;
  logic        prevHeld = 1'b0;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallD       (stallD),
    .pcsrcD       (pcsrcD),
    .jumpD        (jumpD),
    .pcbranchD    (pcbranchD),
    .pcjumpD      (pcjumpD),
    .instrD       (instrD),
    .pcD          (pcD),
    .validD       (validD),
    .adelD        (adelD),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder: records accepted addresses and returns them in order after busLat cycles.
  always @(negedge clk) begin
    if (!rst) busQ.delete();
    else begin
      if (inst_data_ok && busQ.size() > 0) void'(busQ.pop_front());
      if (inst_req && inst_addr_ok) busQ.push_back('{addr: inst_addr, ready: cyc + busLat});
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst || busQ.size() == 0 || busQ[0].ready > cyc) begin
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
    end else begin
      inst_data_ok = 1'b1;
      inst_rdata   = busQ[0].addr;
    end
  end

  // Program-order model: each instruction decode consumes must be the sequential
  // successor of the previous one, or the target if the previous one redirected.
  always @(negedge clk) begin
    logic [31:0] tgt;
    if (!rst) begin
      expPc    = RST_PC;
      expReq   = RST_PC;
      prevHeld = 1'b0;
    end else begin
      if (inst_req && inst_addr_ok) begin
        checkOutput("reqAddr", inst_addr, expReq);
        checkOutput("reqAligned", {30'b0, inst_addr[1:0]}, 32'd0);
        expReq = expReq + 32'd4;
        acceptCount++;
      end
      if (prevHeld && !validD) begin
        checkOutput("holdValid", {31'b0, validD}, 32'd1);
        prevHeld = 1'b0;
      end else if (validD) begin
        if (prevHeld) begin
          checkOutput("holdPc", pcD, heldPc);
          checkOutput("holdInstr", instrD, heldInstr);
        end else begin
          checkOutput("streamPc", pcD, expPc);
          checkOutput("streamInstr", instrD, (expPc[1:0] != 2'b00) ? 32'd0 : expPc);
          checkOutput("streamAdel", {31'b0, adelD}, {31'b0, expPc[1:0] != 2'b00});
        end
        if (stallD) begin
          prevHeld  = 1'b1;
          heldPc    = pcD;
          heldInstr = instrD;
        end else begin
          prevHeld = 1'b0;
          if (jumpD || pcsrcD) begin
            tgt = jumpD ? pcjumpD : pcbranchD;
`ifndef FETCH_ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            checkOutput("redirectNoReq", {31'b0, inst_req}, 32'd0);
            expPc  = tgt;
            expReq = tgt;
          end else begin
            expPc = pcD + 32'd4;
          end
        end
      end else begin
        checkOutput("bubbleInstr", instrD, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic stall, input logic branch, input logic jump,
                               input logic [31:0] bt, input logic [31:0] jt);
    @(posedge clk);
    #2;
    stallD    = stall;
    pcsrcD    = branch;
    jumpD     = jump;
    pcbranchD = bt;
    pcjumpD   = jt;
  endtask

  task automatic redirectWhenValid(input logic branch, input logic jump, input logic [31:0] bt,
                                   input logic [31:0] jt, input logic needData);
    logic found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #2;
      if (validD && (!needData || inst_data_ok)) begin
        stallD    = 1'b0;
        pcsrcD    = branch;
        jumpD     = jump;
        pcbranchD = bt;
        pcjumpD   = jt;
        found     = 1'b1;
      end
    end
    checkOutput("redirectWindow", {31'b0, found}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic waitDecodePc(input string name, input logic [31:0] target, input int budget,
                              output int waited);
    logic found = 1'b0;
    waited = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      waited++;
      if (validD && pcD === target) found = 1'b1;
    end
    checkOutput(name, {31'b0, found}, 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_instReq"}, {31'b0, inst_req}, 32'd0);
    checkOutput({tag, "_instAddr"}, inst_addr, RST_PC);
    checkOutput({tag, "_instrD"}, instrD, 32'd0);
    checkOutput({tag, "_pcD"}, pcD, 32'd0);
    checkOutput({tag, "_validD"}, {31'b0, validD}, 32'd0);
    checkOutput({tag, "_adelD"}, {31'b0, adelD}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int acceptsBefore;

    // Reset values and the first request one cycle after release.
    repeat (3) @(posedge clk);
    #3;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reqBeforeEdge", {31'b0, inst_req}, 32'd0);
    @(negedge clk);
    checkOutput("firstReq", {31'b0, inst_req}, 32'd1);
    checkOutput("firstAddr", inst_addr, RST_PC);
    @(negedge clk);
    checkOutput("noValidYet", {31'b0, validD}, 32'd0);
    @(negedge clk);
    checkOutput("firstValid", {31'b0, validD}, 32'd1);
    checkOutput("firstPc", pcD, RST_PC);
    checkOutput("firstInstr", instrD, RST_PC);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("streamValid", {31'b0, validD}, 32'd1);
    end

    // Stall for five cycles: decode held, requests bounded by the prefetch credit.
    acceptsBefore = acceptCount;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("stallCredit", {31'b0, (acceptCount - acceptsBefore) <= DEPTH}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // Branch with responses in flight on a three-cycle bus.
    busLat = 3;
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    redirectWhenValid(1'b1, 1'b0, 32'hBFC0_0100, '0, 1'b0);
    waitDecodePc("branchTarget", 32'hBFC0_0100, 30, waited);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // Jump (with a competing branch) coincident with a returning word on a zero-wait bus.
    busLat = 1;
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    redirectWhenValid(1'b1, 1'b1, 32'hDEAD_0000, 32'h8000_0000, 1'b1);
    waitDecodePc("jumpTarget", 32'h8000_0000, 20, waited);
    checkOutput("jumpLatency", waited, 32'd3);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

`ifdef FETCH_ALIGN_CHECK_EN
    redirectWhenValid(1'b0, 1'b1, '0, 32'h8000_0002, 1'b0);
    waitDecodePc("adelEntry", 32'h8000_0002, 20, waited);
    checkOutput("adelFlag", {31'b0, adelD}, 32'd1);
    checkOutput("adelInstr", instrD, 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    redirectWhenValid(1'b0, 1'b1, '0, 32'h8000_0010, 1'b0);
    waitDecodePc("afterAdel", 32'h8000_0010, 20, waited);
`else
    redirectWhenValid(1'b0, 1'b1, '0, 32'h8000_0046, 1'b0);
    waitDecodePc("alignedTarget", 32'h8000_0044, 20, waited);
`endif
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // Asynchronous reset between edges, then refetch from the reset vector.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkResetValues("asyncReset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    waitDecodePc("refetch", RST_PC, 10, waited);
    checkOutput("refetchLatency", waited, 32'd3);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
